root_square_radix4: RTL and testbench
=====================================

ROOT_SQUARE_RADIX4 -- requirements
Module: root_square_radix4

Interface
REQ-001 The module SHALL have the port clock, input, 1 bit, the single rising-edge clock for all state.
REQ-002 The module SHALL have the port reset, input, 1 bit, a synchronous active-high reset.
REQ-003 The module SHALL have the port q, input, 32 bits, the root operand as an unsigned fraction .1xxx...x, sampled only on start.
REQ-004 The module SHALL have the port start, input, 1 bit, a one-cycle request issued by the ID stage as is_square & ~busy.
REQ-005 The module SHALL have the port d, output, 32 bits, the squared radicand as a fraction .01xx...x or .1xxx...x.
REQ-006 The module SHALL have the port busy, output, 1 bit; while it is 1 the module cannot accept a new operation.
REQ-007 The module SHALL have the port ready, output, 1 bit, a one-cycle pulse marking d valid for the CPU.
REQ-008 The module SHALL have the port count, output, 5 bits, the iteration counter exposed for simulation only.
REQ-009 The module SHALL have the port inexact, output, 1 bit, present only under REQ-024.

Function
REQ-010 The module SHALL compute P = q*q as an exact 64-bit unsigned product by radix-4 shift-add, consuming 2 multiplier bits of q per iteration, LSB first, over 16 iterations.
REQ-011 Each iteration SHALL add digit*q (0, q, 2q, or 3q, with 3q precomputed at start as 34 bits) to the upper accumulator, then shift the 66-bit accumulator right by 2.
REQ-012 The result SHALL be d = P[63:32] with bit 0 ORed with (P[31:0] != 0) (sticky jam); no increment and no overflow are possible.
REQ-013 A start sampled at edge N SHALL load the operand and 3q, clear count and the accumulator, and set busy.
REQ-014 Iterations SHALL occur at edges N+1 through N+16, with count incrementing at each; busy SHALL clear at edge N+16 when count == 15.
REQ-015 ready SHALL equal ~busy & busy_q, where busy_q is busy delayed one cycle, so it is high exactly in the cycle after edge N+16.
REQ-016 d SHALL hold its value from the ready cycle until the next accepted start.
REQ-017 A start that arrives while busy = 1 SHALL be ignored, with no reload and no effect on the operation in flight.
REQ-018 A start in the ready cycle SHALL be accepted, with back-to-back throughput of one result per 17 cycles.
REQ-019 The operand q = 0 SHALL produce d = 0 after the full 16-iteration latency, with no early termination.

Reset
REQ-020 While reset = 1 at a clock edge, busy, busy_q, count, the accumulator, d and inexact SHALL all become 0, and ready SHALL therefore be 0.
REQ-021 A reset mid-operation SHALL abort the operation, produce no ready pulse, and leave the module ready to accept a start on the first edge after reset deasserts.
REQ-022 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-023 The feature macro SHALL be ROOT_SQUARE_INEXACT_EN.
REQ-024 When ROOT_SQUARE_INEXACT_EN is defined, the inexact port SHALL exist and equal (P[31:0] != 0), valid with d and held with it.
REQ-025 When ROOT_SQUARE_INEXACT_EN is undefined, the inexact port and its logic SHALL be absent, and d SHALL be unchanged.

Structure
REQ-026 A shared package root_pkg SHALL hold the operand width (32), the accumulator width (66), the iteration count (16), and the count width (5).
REQ-027 The per-iteration digit select-and-add SHALL be a combinational sub-module root_square_step (inputs: accumulator, q, 3q, digit; output: next accumulator).
REQ-028 All registers SHALL reside in root_square_radix4.

Verification
REQ-029 q = 0x80000000, start -> ready 17 cycles after start, d = 0x40000000, inexact = 0.
REQ-030 q = 0xC0000000 -> d = 0x90000000, inexact = 0.
REQ-031 q = 0xFFFFFFFF -> P = 0xFFFFFFFE_00000001, so d = 0xFFFFFFFF and inexact = 1.
REQ-032 q = 0x80000001 with start re-pulsed at cycle 5 -> the second start is ignored, d = 0x40000001, inexact = 1, single ready pulse.
REQ-033 Start, then reset at iteration 8, then start with q = 0x80000000 -> no ready pulse for the aborted operation, then d = 0x40000000.
REQ-034 Back-to-back start in each ready cycle over 100 random operands -> every d matches a 64-bit reference square with sticky jam.

Source files
------------

// File: rtl/root_pkg.sv
// Shared widths and helpers for the radix-4 squaring unit.
package root_pkg;

  localparam int unsigned OpW     = 32;
  localparam int unsigned AccW    = 66;
  localparam int unsigned NumIter = 16;
  localparam int unsigned CntW    = 5;

  // Upper half of the 64-bit square with all discarded low bits jammed into bit 0.
  function automatic logic [OpW-1:0] sticky_jam(input logic [2*OpW-1:0] p);
    return {p[2*OpW-1:OpW+1], p[OpW] | (|p[OpW-1:0])};
  endfunction

endpackage

// File: rtl/root_square_step.sv
// One radix-4 shift-add iteration: add digit*q to the upper accumulator, then shift right by 2.
module root_square_step
  import root_pkg::*;
(
  input  logic [AccW-1:0] acc_i,
  input  logic [OpW-1:0]  q_i,
  input  logic [OpW+1:0]  q3_i,
  input  logic [1:0]      digit_i,
  output logic [AccW-1:0] acc_o
);

  logic [OpW+1:0]  addend;
  logic [AccW-1:0] acc_sum;

  always_comb begin
    addend = '0;
    unique case (digit_i)
      2'd0: addend = '0;
      2'd1: addend = {2'b00, q_i};
      2'd2: addend = {1'b0, q_i, 1'b0};
      2'd3: addend = q3_i;
    endcase
    // Upper part stays below q before the add, so the 34-bit sum cannot overflow.
    acc_sum = {acc_i[AccW-1:OpW] + addend, acc_i[OpW-1:0]};
    acc_o   = acc_sum >> 2;
  end

endmodule

// File: rtl/root_square_radix4.sv
// Iterative radix-4 squarer d = q*q (upper half, sticky jam), 16 iterations per result.
// Optional inexact output enabled by defining ROOT_SQUARE_INEXACT_EN.
module root_square_radix4
  import root_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [OpW-1:0]  q,
  input  logic            start,
  output logic [OpW-1:0]  d,
  output logic            busy,
  output logic            ready,
`ifdef ROOT_SQUARE_INEXACT_EN
  output logic            inexact,
`endif
  output logic [CntW-1:0] count
);

  logic [AccW-1:0] acc_q, acc_d, acc_step;
  logic [OpW-1:0]  opnd_q, opnd_d;
  logic [OpW-1:0]  mplr_q, mplr_d;
  logic [OpW+1:0]  q3_q, q3_d;
  logic [CntW-1:0] count_q, count_d;
  logic [OpW-1:0]  d_q, d_d;
  logic            busy_q, busy_d;
  logic            busy_dly_q, busy_dly_d;
`ifdef ROOT_SQUARE_INEXACT_EN
  logic            inexact_q, inexact_d;
`endif

  root_square_step u_step (
    .acc_i   (acc_q),
    .q_i     (opnd_q),
    .q3_i    (q3_q),
    .digit_i (mplr_q[1:0]),
    .acc_o   (acc_step)
  );

  always_comb begin
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    mplr_d     = mplr_q;
    q3_d       = q3_q;
    count_d    = count_q;
    d_d        = d_q;
    busy_d     = busy_q;
    busy_dly_d = busy_q;
`ifdef ROOT_SQUARE_INEXACT_EN
    inexact_d  = inexact_q;
`endif
    if (start && !busy_q) begin
      opnd_d  = q;
      mplr_d  = q;
      q3_d    = {2'b00, q} + {1'b0, q, 1'b0};
      acc_d   = '0;
      count_d = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      acc_d   = acc_step;
      mplr_d  = mplr_q >> 2;
      count_d = count_q + CntW'(1);
      if (count_q == CntW'(NumIter - 1)) begin
        busy_d = 1'b0;
        d_d    = sticky_jam(acc_step[2*OpW-1:0]);
`ifdef ROOT_SQUARE_INEXACT_EN
        inexact_d = |acc_step[OpW-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q      <= '0;
      opnd_q     <= '0;
      mplr_q     <= '0;
      q3_q       <= '0;
      count_q    <= '0;
      d_q        <= '0;
      busy_q     <= 1'b0;
      busy_dly_q <= 1'b0;
`ifdef ROOT_SQUARE_INEXACT_EN
      inexact_q  <= 1'b0;
`endif
    end else begin
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      mplr_q     <= mplr_d;
      q3_q       <= q3_d;
      count_q    <= count_d;
      d_q        <= d_d;
      busy_q     <= busy_d;
      busy_dly_q <= busy_dly_d;
`ifdef ROOT_SQUARE_INEXACT_EN
      inexact_q  <= inexact_d;
`endif
    end
  end

  assign d     = d_q;
  assign busy  = busy_q;
  assign ready = ~busy_q & busy_dly_q;
  assign count = count_q;
`ifdef ROOT_SQUARE_INEXACT_EN
  assign inexact = inexact_q;
`endif

endmodule

// File: tb/tb_root_square_radix4.sv
// Directed self-checking bench for root_square_radix4 (inexact checks when ROOT_SQUARE_INEXACT_EN).
module tb_root_square_radix4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] q;
  logic        start;
  logic [31:0] d;
  logic        busy;
  logic        ready;
  logic [4:0]  count;
`ifdef ROOT_SQUARE_INEXACT_EN
  logic        inexact;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  root_square_radix4 dut (
    .clock   (clock),
    .reset   (reset),
    .q       (q),
    .start   (start),
    .d       (d),
    .busy    (busy),
    .ready   (ready),
`ifdef ROOT_SQUARE_INEXACT_EN
    .inexact (inexact),
`endif
    .count   (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_inexact(input string tag, input logic exp);
`ifdef ROOT_SQUARE_INEXACT_EN
    check(tag, {31'd0, inexact}, {31'd0, exp});
`else
    if (exp === 1'bx) $display("unused %s", tag);
`endif
  endtask

  function automatic logic [31:0] ref_d(input logic [31:0] a);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, a};
    return {p[63:33], p[32] | (|p[31:0])};
  endfunction

  function automatic logic ref_inexact(input logic [31:0] a);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, a};
    return |p[31:0];
  endfunction

  // Cycle-level wait: start drops after the first edge; returns edges until ready is seen.
  task automatic wait_ready(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clock);
      @(negedge clock);
      n++;
      if (n == 1) start = 1'b0;
      if (ready) break;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a,
                        input logic [31:0] exp_d, input logic exp_inx);
    int n;
    q = a;
    start = 1'b1;
    wait_ready(n);
    check({tag, "_lat"}, n, 32'd17);
    check({tag, "_d"}, d, exp_d);
    check_inexact({tag, "_inx"}, exp_inx);
  endtask

  initial begin
    int n;
    int pulses;
    logic [31:0] cur;
    logic [31:0] nxt;

    reset = 1'b1;
    start = 1'b0;
    q     = 32'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_d", d, 32'd0);
    check_inexact("rst_inx", 1'b0);

    // Start loads and clears the counter.
    q = 32'h8000_0000;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_count", {27'd0, count}, 32'd0);
    n = 1;
    while (n < 40 && !ready) begin
      @(posedge clock);
      @(negedge clock);
      n++;
    end
    check("half_lat", n, 32'd17);
    check("half_d", d, 32'h4000_0000);
    check("half_count", {27'd0, count}, 32'd16);
    check_inexact("half_inx", 1'b0);
    @(posedge clock);
    @(negedge clock);
    check("ready_1cyc", {31'd0, ready}, 32'd0);

    run_op("c0", 32'hC000_0000, 32'h9000_0000, 1'b0);
    run_op("ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op("zero", 32'h0000_0000, 32'h0000_0000, 1'b0);
    repeat (5) @(negedge clock);
    check("hold_d", d, 32'h0000_0000);

    // Re-pulse start while busy: must be ignored.
    q = 32'h8000_0001;
    start = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clock);
      @(negedge clock);
      start = (i == 5);
      if (i == 5) q = 32'hFFFF_FFFF;
      if (ready) begin
        pulses++;
        check("busy_lat", i, 32'd17);
        check("busy_d", d, 32'h4000_0001);
        check_inexact("busy_inx", 1'b1);
      end
    end
    start = 1'b0;
    check("busy_pulses", pulses, 32'd1);

    // Abort with reset at iteration 8; a simultaneous start must lose to reset.
    q = 32'hFFFF_FFFF;
    start = 1'b1;
    repeat (9) begin
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
    end
    reset = 1'b1;
    start = 1'b1;
    q = 32'h1234_5678;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_count", {27'd0, count}, 32'd0);
    check("abort_d", d, 32'd0);
    pulses = 0;
    repeat (25) begin
      @(posedge clock);
      @(negedge clock);
      if (ready) pulses++;
    end
    check("abort_pulses", pulses, 32'd0);
    run_op("after_abort", 32'h8000_0000, 32'h4000_0000, 1'b0);

    // Back-to-back: new start issued in every ready cycle.
    cur = $urandom;
    q = cur;
    start = 1'b1;
    for (int k = 0; k < 100; k++) begin
      wait_ready(n);
      check("b2b_lat", n, 32'd17);
      check("b2b_d", d, ref_d(cur));
      check_inexact("b2b_inx", ref_inexact(cur));
      if (k < 99) begin
        nxt = $urandom;
        cur = nxt;
        q = nxt;
        start = 1'b1;
      end
    end
    start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
